des_feistel_iter: RTL and testbench

- Iterative, multi-round Feistel engine on an 8-bit block. Generalises the single-round 8-bit/6-bit-key DES stage to a configurable round count, a wider master key with a rotating key schedule, and encrypt/decrypt modes.
- Computes one round per clock and uses valid/ready handshakes on input and output.
- Sits between the plaintext source and the cipher sink in the crypto datapath.

---
 rtl/des_pkg.sv | 40 ++++
 rtl/des_feistel_iter_round_f.sv | 12 +
 rtl/des_feistel_iter.sv | 109 ++++++++++
 tb/tb_des_feistel_iter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types, constants and round-function helpers for the iterative 8-bit Feistel engine.
// All bit vectors follow DES numbering: index 0 is the most significant bit.
package des_pkg;

    localparam int unsigned HALF_W   = 4;
    localparam int unsigned SUBKEY_W = 6;
    localparam int unsigned BLOCK_W  = 2 * HALF_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // DES S1, row-major, entry 0 in the top nibble
    localparam logic [255:0] S1_TABLE = {
        64'hE4D12FB83A6C5907,
        64'h0F74E2D1A6CB9538,
        64'h41E8D62BFC973A50,
        64'hFC8249175B3EA06D
    };

    function automatic logic [0:SUBKEY_W-1] expand(input logic [0:HALF_W-1] r);
        return {r[0], r[3], r[1], r[2], r[0], r[1]};
    endfunction

    // Row comes from the outer bits, column from the inner four
    function automatic logic [0:HALF_W-1] s1_lookup(input logic [0:SUBKEY_W-1] x);
        logic [5:0]  idx;
        int unsigned pos;
        idx = {x[0], x[5], x[1], x[2], x[3], x[4]};
        pos = 32'd255 - 32'd4 * 32'(idx);
        return S1_TABLE[pos -: 4];
    endfunction

    function automatic logic [0:HALF_W-1] permute(input logic [0:HALF_W-1] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

endpackage

// File: rtl/des_feistel_iter_round_f.sv
// Combinational Feistel round function F(R,K): expand, key mix, S1 substitution, permute.
module des_round_f
    import des_pkg::*;
(
    input  logic [0:HALF_W-1]   r,
    input  logic [0:SUBKEY_W-1] k,
    output logic [0:HALF_W-1]   f_c
);

    assign f_c = permute(s1_lookup(expand(r) ^ k));

endmodule

// File: rtl/des_feistel_iter.sv
// Iterative Feistel engine: one round per clock, rotating key schedule, encrypt/decrypt,
// valid/ready handshakes on both sides.
module des_feistel_iter
    import des_pkg::*;
#(
    parameter int unsigned ROUNDS   = 4,
    parameter int unsigned KEY_W    = 9,
    parameter int unsigned KEY_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:7]         in_block,
    input  logic [0:KEY_W-1]   in_key,
    input  logic               in_decrypt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:7]         out_block,
    output logic               busy
);

    localparam int unsigned      RND_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    state_t              state;
    logic [RND_W-1:0]    rnd;
    logic [0:HALF_W-1]   l_q;
    logic [0:HALF_W-1]   r_q;
    logic [0:KEY_W-1]    key_q;
    logic                dec_q;

    logic [0:SUBKEY_W-1] sched [ROUNDS];
    logic [RND_W-1:0]    sched_idx_c;
    logic [0:SUBKEY_W-1] subkey_c;
    logic [0:HALF_W-1]   f_c;
    logic [0:HALF_W-1]   r_next_c;

    // Subkey j is six key bits read cyclically from position j*KEY_STEP
    for (genvar g = 0; g < ROUNDS; g++) begin : g_sched
        for (genvar b = 0; b < SUBKEY_W; b++) begin : g_bit
            localparam int unsigned POS = (g * KEY_STEP + b) % KEY_W;
            assign sched[g][b] = key_q[POS];
        end
    end

    // Decrypt walks the schedule backwards
    assign sched_idx_c = dec_q ? (LAST_RND - rnd) : rnd;
    assign subkey_c    = sched[sched_idx_c];

    des_round_f u_round_f (
        .r   (r_q),
        .k   (subkey_c),
        .f_c (f_c)
    );

    assign r_next_c = l_q ^ f_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rnd       <= '0;
            l_q       <= '0;
            r_q       <= '0;
            key_q     <= '0;
            dec_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_block <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        l_q      <= in_decrypt ? in_block[4:7] : in_block[0:3];
                        r_q      <= in_decrypt ? in_block[0:3] : in_block[4:7];
                        key_q    <= in_key;
                        dec_q    <= in_decrypt;
                        rnd      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    l_q <= r_q;
                    r_q <= r_next_c;
                    rnd <= rnd + 1'b1;
                    if (rnd == LAST_RND) begin
                        // Decrypt swaps the halves back on the way out
                        out_block <= dec_q ? {r_next_c, r_q} : {r_q, r_next_c};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_feistel_iter.sv
// Bench for des_feistel_iter: single-round and default-parameter instances, directed vectors,
// round-trip sweep, backpressure, mid-run reset and input wiggling during a block.
module tb_des_feistel_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: ROUNDS=1, KEY_W=6
    logic       in_valid_a, in_ready_a, in_decrypt_a, out_valid_a, out_ready_a, busy_a;
    logic [0:7] in_block_a, out_block_a;
    logic [0:5] in_key_a;

    // Instance B: default parameters
    logic       in_valid_b, in_ready_b, in_decrypt_b, out_valid_b, out_ready_b, busy_b;
    logic [0:7] in_block_b, out_block_b;
    logic [0:8] in_key_b;

    int checks = 0;
    int errors = 0;

    des_feistel_iter #(.ROUNDS(1), .KEY_W(6), .KEY_STEP(0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_block(in_block_a),
        .in_key(in_key_a), .in_decrypt(in_decrypt_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_block(out_block_a),
        .busy(busy_a)
    );

    des_feistel_iter dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block_b),
        .in_key(in_key_b), .in_decrypt(in_decrypt_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_block(out_block_b),
        .busy(busy_b)
    );

    typedef struct {
        logic [7:0] blk;
        logic [8:0] key;
        logic       dec;
        logic [7:0] exp;
    } vec_t;

    vec_t va [7];
    vec_t vb [2];

    int s1 [4][16] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
        '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
        '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
        '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model on descending vectors; key bit i (MSB-first) is key[kw-1-i]
    function automatic logic [7:0] model(input logic [7:0] blk, input int unsigned key,
                                         input int kw, input int rounds, input int step,
                                         input logic dec);
        logic [3:0] l, r, f, t, sv;
        logic [5:0] e, k, x;
        int         j, pos, row, col, bi;
        l = dec ? blk[3:0] : blk[7:4];
        r = dec ? blk[7:4] : blk[3:0];
        for (int rr = 0; rr < rounds; rr++) begin
            j   = dec ? (rounds - 1 - rr) : rr;
            pos = (j * step) % kw;
            for (int i = 0; i < 6; i++) begin
                bi       = (pos + i) % kw;
                k[5 - i] = 1'((key >> (kw - 1 - bi)) & 1);
            end
            e   = {r[3], r[0], r[2], r[1], r[3], r[2]};
            x   = e ^ k;
            row = {30'd0, x[5], x[0]};
            col = {28'd0, x[4:1]};
            sv  = 4'(s1[row][col]);
            f   = {sv[1], sv[3], sv[2], sv[0]};
            t   = l ^ f;
            l   = r;
            r   = t;
        end
        return dec ? {r, l} : {l, r};
    endfunction

    task automatic xfer_a(input logic [7:0] blk, input logic [5:0] key, input logic dec,
                          output logic [7:0] res, output int lat);
        int n = 0;
        while (!in_ready_a && n < 20) begin @(posedge clk); #1; n++; end
        in_valid_a = 1'b1; in_block_a = blk; in_key_a = key; in_decrypt_a = dec;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        lat = 0;
        while (!out_valid_a && lat < 20) begin @(posedge clk); #1; lat++; end
        res = out_block_a;
        @(posedge clk); #1;
    endtask

    task automatic xfer_b(input logic [7:0] blk, input logic [8:0] key, input logic dec,
                          output logic [7:0] res, output int lat);
        int n = 0;
        while (!in_ready_b && n < 20) begin @(posedge clk); #1; n++; end
        in_valid_b = 1'b1; in_block_b = blk; in_key_b = key; in_decrypt_b = dec;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        lat = 0;
        while (!out_valid_b && lat < 20) begin @(posedge clk); #1; lat++; end
        res = out_block_b;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] res, res2, exp;
        logic [8:0] key;
        int         lat, lat2, n;

        va = '{
            '{8'h56, 9'h02C, 1'b0, 8'h6A},
            '{8'h6A, 9'h02C, 1'b1, 8'h56},
            '{8'h00, 9'h000, 1'b0, 8'h0E},
            '{8'hFF, 9'h03F, 1'b0, 8'hF1},
            '{8'hF1, 9'h03F, 1'b1, 8'hFF},
            '{8'h3C, 9'h015, 1'b0, 8'hC3},
            '{8'hA7, 9'h032, 1'b0, 8'h71}
        };
        vb = '{
            '{8'h56, 9'h167, 1'b0, 8'hCC},
            '{8'hCC, 9'h167, 1'b1, 8'h56}
        };

        rst = 1'b1;
        in_valid_a = 1'b0; in_block_a = '0; in_key_a = '0; in_decrypt_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_block_b = '0; in_key_b = '0; in_decrypt_b = 1'b0; out_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_a", 32'(in_ready_a), 1);
        check("rst_out_valid_a", 32'(out_valid_a), 0);
        check("rst_out_block_a", 32'(out_block_a), 0);
        check("rst_busy_a", 32'(busy_a), 0);
        check("rst_in_ready_b", 32'(in_ready_b), 1);
        check("rst_out_valid_b", 32'(out_valid_b), 0);
        check("rst_busy_b", 32'(busy_b), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-round vectors
        for (int i = 0; i < 7; i++) begin
            xfer_a(va[i].blk, va[i].key[5:0], va[i].dec, res, lat);
            check($sformatf("vec_a%0d_block", i), 32'(res), 32'(va[i].exp));
            check($sformatf("vec_a%0d_latency", i), 32'(lat), 1);
        end

        // Four-round vectors
        for (int i = 0; i < 2; i++) begin
            xfer_b(vb[i].blk, vb[i].key, vb[i].dec, res, lat);
            check($sformatf("vec_b%0d_block", i), 32'(res), 32'(vb[i].exp));
            check($sformatf("vec_b%0d_latency", i), 32'(lat), 4);
        end

        // Round-trip sweep over every block with three random keys
        for (int kk = 0; kk < 3; kk++) begin
            key = 9'($urandom_range(0, 511));
            for (int b = 0; b < 256; b++) begin
                xfer_b(8'(b), key, 1'b0, res, lat);
                exp = model(8'(b), 32'(key), 9, 4, 1, 1'b0);
                check($sformatf("sweep_enc k%0h b%0h", key, b), 32'(res), 32'(exp));
                xfer_b(res, key, 1'b1, res2, lat2);
                check($sformatf("sweep_rt k%0h b%0h", key, b), 32'(res2), 32'(b));
                check($sformatf("sweep_lat k%0h b%0h", key, b), 32'({lat[15:0], lat2[15:0]}),
                      32'h0004_0004);
            end
        end

        // Output backpressure
        out_ready_b = 1'b0;
        in_valid_b = 1'b1; in_block_b = 8'h56; in_key_b = 9'h167; in_decrypt_b = 1'b0;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        n = 0;
        while (!out_valid_b && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_latency", 32'(n), 4);
        for (int i = 0; i < 5; i++) begin
            in_valid_b = 1'b1;
            in_block_b = 8'($urandom);
            @(posedge clk); #1;
            check($sformatf("bp_hold_block%0d", i), 32'(out_block_b), 32'h0CC);
            check($sformatf("bp_hold_valid%0d", i), 32'(out_valid_b), 1);
            check($sformatf("bp_hold_ready%0d", i), 32'(in_ready_b), 0);
        end
        in_valid_b = 1'b0;
        out_ready_b = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid_b), 0);
        check("bp_release_in_ready", 32'(in_ready_b), 1);
        check("bp_release_busy", 32'(busy_b), 0);
        check("bp_release_keep_block", 32'(out_block_b), 32'h0CC);

        // Asynchronous reset in the middle of a block
        in_valid_b = 1'b1; in_block_b = 8'h9E; in_key_b = 9'h0F3; in_decrypt_b = 1'b0;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("mid_run_busy", 32'(busy_b), 1);
        rst = 1'b1;
        #1;
        check("async_rst_in_ready", 32'(in_ready_b), 1);
        check("async_rst_out_valid", 32'(out_valid_b), 0);
        check("async_rst_out_block", 32'(out_block_b), 0);
        check("async_rst_busy", 32'(busy_b), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_stale_valid", 32'(out_valid_b), 0);
        xfer_b(8'h3A, 9'h1C5, 1'b0, res, lat);
        check("post_rst_block", 32'(res), 32'(model(8'h3A, 32'h1C5, 9, 4, 1, 1'b0)));
        check("post_rst_latency", 32'(lat), 4);

        // Key, mode and block wiggled during RUN must not affect the result
        in_valid_b = 1'b1; in_block_b = 8'hB4; in_key_b = 9'h0A5; in_decrypt_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        n = 0;
        while (!out_valid_b && n < 20) begin
            in_key_b     = 9'($urandom);
            in_decrypt_b = 1'($urandom);
            in_block_b   = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check("wiggle_block", 32'(out_block_b), 32'(model(8'hB4, 32'h0A5, 9, 4, 1, 1'b1)));
        check("wiggle_latency", 32'(n), 4);
        @(posedge clk); #1;
        check("wiggle_idle", 32'(in_ready_b), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
